// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch control slice.
//   state_e      : fetch FSM states
//   REG_ADDR_W   : default register-specifier width
//   NOP_INSTR    : encoding loaded into IF/ID on a flush
//   cfg_ok()     : elaboration sanity check of the unit's parameters
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RUN       = 2'd1,
    MC_STALL  = 2'd2,
    IMEM_WAIT = 2'd3
  } state_e;

  localparam int REG_ADDR_W = 5;

  // sll $0,$0,0 -- all-zero word is the canonical NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic bit cfg_ok(input int width, input int mc_latency,
                                input int reset_hold, input int cnt_w);
    return (width >= 1) && (mc_latency >= 2) && (reset_hold >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/fetch_control_unit_load_use_detect.sv
// Load-use hazard comparator.
//   i_mem_read : instruction in EX is a load
//   i_ex_rt    : load destination register
//   i_id_rs    : ID source register 1
//   i_id_rt    : ID source register 2
//   o_lu       : ID instruction consumes the load result next cycle
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  output logic                  o_lu
);

  // $0 is hard-wired, so a load targeting it can never create a dependency
  assign o_lu = i_mem_read && (i_ex_rt != '0) &&
                ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/fetch_control_unit.sv
// Instruction-fetch stage sequencer.
// Inputs : clk, reset_n (async, active-low), branch_taken, id_ex_mem_read,
//          id_ex_rt, if_id_rs, if_id_rt, ex_mc_start, imem_ready
// Outputs: pc_enable, PCSrc, if_id_write, if_id_flush, id_ex_bubble,
//          stall_cycles (saturating count of post-reset cycles with pc_enable=0)
// Control outputs are combinational from state and inputs; priority is
// branch > load-use > multi-cycle stall > imem wait > run.
module fetch_control_unit
  import fetch_ctrl_pkg::*;
#(
  parameter int Width      = 32,
  parameter int REG_ADDR_W = fetch_ctrl_pkg::REG_ADDR_W,
  parameter int MC_LATENCY = 4,
  parameter int RESET_HOLD = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  branch_taken,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  ex_mc_start,
  input  logic                  imem_ready,
  output logic                  pc_enable,
  output logic                  PCSrc,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int  HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int  MC_W   = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  localparam bit  CFG_OK = cfg_ok(Width, MC_LATENCY, RESET_HOLD, CNT_W);

  state_e            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [MC_W-1:0]   r_mc_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_lu;
  logic              w_mc_start;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
    .i_mem_read (id_ex_mem_read),
    .i_ex_rt    (id_ex_rt),
    .i_id_rs    (if_id_rs),
    .i_id_rt    (if_id_rt),
    .o_lu       (w_lu)
  );

  // A multi-cycle op only arms the stall from the flowing states; a branch
  // in the same cycle squashes it.
  assign w_mc_start = ex_mc_start && !branch_taken &&
                      ((r_state == RUN) || (r_state == IMEM_WAIT));

  always_comb begin
    pc_enable    = 1'b1;
    PCSrc        = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (r_state == HOLD) begin
      pc_enable    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      // redirect proceeds even with imem not ready: the fetch restarts anyway
      PCSrc        = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_lu) begin
      pc_enable    = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (r_state == MC_STALL) begin
      // EX keeps its op, so no bubble; IF/ID frozen
      pc_enable    = 1'b0;
      if_id_write  = 1'b0;
    end else if (!imem_ready) begin
      pc_enable    = 1'b0;
      if_id_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= HOLD;
      r_hold_cnt  <= HOLD_W'(RESET_HOLD - 1);
      r_mc_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state == HOLD) begin
        if (r_hold_cnt == '0) r_state <= RUN;
        else                  r_hold_cnt <= r_hold_cnt - 1'b1;
      end else if (branch_taken) begin
        r_state <= RUN;
      end else if (w_mc_start) begin
        r_state  <= MC_STALL;
        r_mc_cnt <= MC_W'(MC_LATENCY - 2);
      end else if (w_lu) begin
        r_state <= r_state;  // single-cycle freeze, counters untouched
      end else if (r_state == MC_STALL) begin
        if (r_mc_cnt == '0) r_state <= imem_ready ? RUN : IMEM_WAIT;
        else                r_mc_cnt <= r_mc_cnt - 1'b1;
      end else if (!imem_ready) begin
        r_state <= IMEM_WAIT;
      end else begin
        r_state <= RUN;
      end

      if ((r_state != HOLD) && !pc_enable && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cnt;

  a_cfg: assert property (@(posedge clk) CFG_OK);

  // a second multi-cycle start while one is still stalling is a protocol error
  a_mc_overlap: assert property (@(posedge clk) disable iff (!reset_n)
                                 !(ex_mc_start && (r_state == MC_STALL)));

endmodule
